// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and helpers for the keypad digit encoder.
// Imported by the encoder sub-module and the top-level FSM.
package keypad_pkg;

   localparam int KEY_W                   = 10;
   localparam int DIGIT_W                 = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      DEBOUNCE     = 2'd1,
      LOAD         = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

   // A pattern is one-hot when it is nonzero and clearing its lowest set bit leaves nothing.
   function automatic logic key_is_onehot(input logic [KEY_W-1:0] key);
      return (key != {KEY_W{1'b0}}) &&
             ((key & (key - KEY_W'(1))) == {KEY_W{1'b0}});
   endfunction

endpackage

// File: rtl/keypad_onehot_encoder.sv
// Combinational one-hot to BCD encoder with a single-key qualification flag.
// The digit output is only meaningful when onehot is high.
module keypad_onehot_encoder
   import keypad_pkg::*;
(
   input  logic [KEY_W-1:0]   key,
   output logic [DIGIT_W-1:0] digit,
   output logic               onehot
);

   // OR together the indices of every set line; exact for single-key patterns.
   always_comb begin
      digit  = {DIGIT_W{1'b0}};
      onehot = key_is_onehot(key);
      for (int i = 0; i < KEY_W; i++) begin
         digit = digit | ({DIGIT_W{key[i]}} & DIGIT_W'(i));
      end
   end

endmodule

// File: rtl/keypad_digit_encoder.sv
// Debounced one-hot keypad to BCD digit front end for the timer load interface.
// Emits one active-low loadn strobe per accepted keypress; no auto-repeat.
module keypad_digit_encoder
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 8
) (
   input  logic               clock,
   input  logic               clrn,
   input  logic               enablen,
   input  logic [KEY_W-1:0]   keypad,
   output logic [DIGIT_W-1:0] data,
   output logic               loadn,
   output logic               valid
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [KEY_W-1:0]     key_q, key_d;
   logic [DIGIT_W-1:0]   data_q, data_d;
   logic                 loadn_q, loadn_d;
   logic                 valid_q, valid_d;
   logic [DIGIT_W-1:0]   enc_digit_s;
   logic                 enc_onehot_s;

   // The live keypad equals the captured key whenever data is loaded, so one encoder serves both uses.
   keypad_onehot_encoder u_encoder (
      .key    (keypad),
      .digit  (enc_digit_s),
      .onehot (enc_onehot_s)
   );

   // Next-state, counter, capture and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (!enablen && enc_onehot_s) begin
               key_d   = keypad;
               state_d = DEBOUNCE;
            end else begin
               state_d = IDLE;
            end
         end
         DEBOUNCE: begin
            if (enablen || (keypad != key_q)) begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
               state_d = LOAD;
               data_d  = enc_digit_s;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOAD: begin
            state_d = WAIT_RELEASE;
            cnt_d   = {CNT_W{1'b0}};
         end
         WAIT_RELEASE: begin
            if (keypad == {KEY_W{1'b0}}) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
                  cnt_d   = {CNT_W{1'b0}};
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               cnt_d = {CNT_W{1'b0}};
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      loadn_d = (state_d != LOAD);
      valid_d = (state_d == LOAD) || (state_d == WAIT_RELEASE);
   end

   // State and output registers; reset may hit at any point in the sequence.
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         key_q   <= {KEY_W{1'b0}};
         data_q  <= {DIGIT_W{1'b0}};
         loadn_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         data_q  <= data_d;
         loadn_q <= loadn_d;
         valid_q <= valid_d;
      end
   end

   assign data  = data_q;
   assign loadn = loadn_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_keypad_digit_encoder.sv
// Directed self-checking bench for keypad_digit_encoder with DEBOUNCE_CYCLES=4.
module tb_keypad_digit_encoder;

   logic       clock;
   logic       clrn;
   logic       enablen;
   logic [9:0] keypad;
   logic [3:0] data;
   logic       loadn;
   logic       valid;

   int n_checks;
   int n_pass;
   int pulses;
   int p0;

   keypad_digit_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
      .clock   (clock),
      .clrn    (clrn),
      .enablen (enablen),
      .keypad  (keypad),
      .data    (data),
      .loadn   (loadn),
      .valid   (valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count every cycle the load strobe is low, sampled away from the active edge.
   always @(negedge clock) begin
      if (!loadn) pulses <= pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      pulses   = 0;
      clrn     = 1'b0;
      enablen  = 1'b0;
      keypad   = 10'd0;
      #12;
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_loadn", 32'(loadn), 32'd1);
      chk("rst_valid", 32'(valid), 32'd0);
      tick(1);
      clrn = 1'b1;
      tick(1);

      // Digit 5 held 10 edges, then released
      p0 = pulses;
      keypad = 10'b0000100000;
      tick(4);
      chk("d5_early_loadn", 32'(loadn), 32'd1);
      tick(1);
      chk("d5_loadn_low", 32'(loadn), 32'd0);
      chk("d5_data", 32'(data), 32'd5);
      chk("d5_valid", 32'(valid), 32'd1);
      tick(1);
      chk("d5_loadn_one_cycle", 32'(loadn), 32'd1);
      tick(4);
      chk("d5_valid_held", 32'(valid), 32'd1);
      keypad = 10'd0;
      tick(3);
      chk("d5_valid_rel3", 32'(valid), 32'd1);
      tick(1);
      chk("d5_valid_rel4", 32'(valid), 32'd0);
      chk("d5_pulses", 32'(pulses - p0), 32'd1);

      // Bounce on digit 7: 2 high, 1 low, 6 high
      p0 = pulses;
      keypad = 10'b0010000000;
      tick(2);
      keypad = 10'd0;
      tick(1);
      keypad = 10'b0010000000;
      tick(4);
      chk("bnc_no_early", 32'(pulses - p0), 32'd0);
      chk("bnc_loadn_hi", 32'(loadn), 32'd1);
      tick(1);
      chk("bnc_loadn_low", 32'(loadn), 32'd0);
      chk("bnc_data", 32'(data), 32'd7);
      tick(1);
      keypad = 10'd0;
      tick(5);
      chk("bnc_pulses", 32'(pulses - p0), 32'd1);
      chk("bnc_valid_off", 32'(valid), 32'd0);

      // Sequence 1, 2, 3
      for (int d = 1; d <= 3; d++) begin
         p0 = pulses;
         keypad = 10'(1) << d;
         tick(5);
         chk("seq_loadn", 32'(loadn), 32'd0);
         chk("seq_data", 32'(data), 32'(d));
         tick(1);
         keypad = 10'd0;
         tick(6);
         chk("seq_pulses", 32'(pulses - p0), 32'd1);
      end

      // Two keys at once
      p0 = pulses;
      keypad = 10'b0100001000;
      tick(6);
      chk("two_pulses", 32'(pulses - p0), 32'd0);
      chk("two_data", 32'(data), 32'd3);
      chk("two_valid", 32'(valid), 32'd0);
      keypad = 10'd0;
      tick(1);

      // Entry blocked while enablen is high, then released mid-hold
      p0 = pulses;
      enablen = 1'b1;
      keypad = 10'b1000000000;
      tick(6);
      chk("en_pulses", 32'(pulses - p0), 32'd0);
      chk("en_valid", 32'(valid), 32'd0);
      chk("en_data", 32'(data), 32'd3);
      enablen = 1'b0;
      tick(4);
      chk("en_early_loadn", 32'(loadn), 32'd1);
      tick(1);
      chk("en_loadn_low", 32'(loadn), 32'd0);
      chk("en_data9", 32'(data), 32'd9);
      keypad = 10'd0;
      tick(6);

      // Reset mid-debounce and again in WAIT_RELEASE with digit 4 held
      p0 = pulses;
      keypad = 10'b0000010000;
      tick(2);
      clrn = 1'b0;
      #1;
      chk("rd_data", 32'(data), 32'd0);
      chk("rd_loadn", 32'(loadn), 32'd1);
      chk("rd_valid", 32'(valid), 32'd0);
      tick(1);
      clrn = 1'b1;
      tick(4);
      chk("rd_reload_early", 32'(loadn), 32'd1);
      tick(1);
      chk("rd_reload_loadn", 32'(loadn), 32'd0);
      chk("rd_reload_data", 32'(data), 32'd4);
      tick(2);
      chk("rw_valid_pre", 32'(valid), 32'd1);
      clrn = 1'b0;
      #1;
      chk("rw_data", 32'(data), 32'd0);
      chk("rw_valid", 32'(valid), 32'd0);
      chk("rw_loadn", 32'(loadn), 32'd1);
      tick(1);
      clrn = 1'b1;
      tick(5);
      chk("rw_reload_loadn", 32'(loadn), 32'd0);
      chk("rw_reload_data", 32'(data), 32'd4);
      tick(3);
      chk("rw_no_repeat", 32'(pulses - p0), 32'd2);
      keypad = 10'd0;
      tick(6);
      chk("rw_valid_off", 32'(valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
